// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage with a one-word
// holding register so back-to-back words stream without gaps.
module piso_serializer #(
  parameter int   WIDTH      = 5,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             so_q;
  logic             sv_q;
  logic             fd_q;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  logic             xfer;
  logic             last;
  logic             do_load;
  logic             step;
  logic             stop;
  logic             to_hold;
  logic [WIDTH-1:0] next_word;

  assign data_ready = rstn && !hold_full;
  assign xfer       = data_valid && data_ready;
  assign last       = (cnt == LAST);
  assign next_word  = hold_full ? hold : data_in;

  // A new word enters the shifter from idle, or at a last bit
  // (from hold first, else bypassing straight from data_in).
  assign do_load = (state == IDLE && xfer) ||
                   (state == SHIFT && last && (hold_full || xfer));
  assign step    = (state == SHIFT) && !last;
  assign stop    = (state == SHIFT) && last && !hold_full && !xfer;
  assign to_hold = xfer && step;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      so_q      <= IDLE_LEVEL;
      sv_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      unique case (1'b1)
        do_load: begin
          state <= SHIFT;
          shreg <= adv(next_word);
          so_q  <= head(next_word);
          sv_q  <= 1'b1;
          fd_q  <= 1'b0;
          cnt   <= '0;
          if (hold_full) hold_full <= 1'b0;
        end
        step: begin
          shreg <= adv(shreg);
          so_q  <= head(shreg);
          cnt   <= cnt + 1'b1;
          fd_q  <= (cnt == LAST_M1);
        end
        stop: begin
          state <= IDLE;
          so_q  <= IDLE_LEVEL;
          sv_q  <= 1'b0;
          fd_q  <= 1'b0;
          cnt   <= '0;
        end
        default: ;
      endcase
      if (to_hold) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end
    end
  end

  assign serial_out   = so_q;
  assign serial_valid = sv_q;
  assign frame_done   = fd_q;
  assign busy         = (state == SHIFT) || hold_full;

endmodule
